symbol_drawer: RTL

// - Renders one GLYPH_WIDTH x GLYPH_HEIGHT character cell into the 1-bpp framebuffer at pixel (x, y).
// - Sits downstream of the accelerator symbol adapter: takes x/y/symbol/cursor flags plus a start pulse,

---
 rtl/symbol_drawer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/symbol_drawer.sv
// rtl/symbol_drawer.sv - renders one glyph cell into a 1-bpp framebuffer
//
// Purpose
//   Draws one GLYPH_WIDTH x GLYPH_HEIGHT character cell with its top-left
//   corner at pixel (x, y). Each glyph row is read from a synchronous glyph
//   ROM. The cell is then written to the framebuffer one pixel per column.
//   Every pixel of the cell is written, foreground as 1 and background as 0,
//   so a redraw fully replaces whatever was in the cell before.
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   single-cycle draw request, only honoured while ready=1
//   ready           out  1 while idle
//   x, y            in   cell top-left pixel position, latched on accepted start
//   symbol          in   glyph index (>= SYMBOL_COUNT draws glyph 0), latched
//   cursor_left     in   force column 0 to foreground, latched
//   cursor_right    in   force column GLYPH_WIDTH-1 to foreground, latched
//   glyph_rom_addr  out  glyph ROM row address (symbol*GLYPH_HEIGHT + row)
//   glyph_rom_data  in   glyph ROM row, valid one cycle after the address
//   fb_write_enable out  framebuffer write request
//   fb_write_addr   out  (y+row)*SCREEN_WIDTH + (x+col), wrapped to FB_ADDR_WIDTH
//   fb_write_data   out  pixel value
//   fb_can_write    in   framebuffer accepts the write this cycle
//
// Build option
//   SYMBOL_DRAWER_CLIP_EN : when defined, pixels outside the screen are
//   skipped (no write request, column advances in one cycle). When it is not
//   defined, every pixel is written at the wrapped address.

module symbol_drawer #(
   parameter int GLYPH_WIDTH    = 8,
   parameter int GLYPH_HEIGHT   = 16,
   parameter int SYMBOL_COUNT   = 128,
   parameter int SCREEN_WIDTH   = 640,
   parameter int SCREEN_HEIGHT  = 480,
   parameter int FB_ADDR_WIDTH  = 19,
   parameter int ROM_ADDR_WIDTH = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      ready,
   input  logic [15:0]               x,
   input  logic [15:0]               y,
   input  logic [15:0]               symbol,
   input  logic                      cursor_left,
   input  logic                      cursor_right,
   output logic [ROM_ADDR_WIDTH-1:0] glyph_rom_addr,
   input  logic [GLYPH_WIDTH-1:0]    glyph_rom_data,
   output logic                      fb_write_enable,
   output logic [FB_ADDR_WIDTH-1:0]  fb_write_addr,
   output logic                      fb_write_data,
   input  logic                      fb_can_write
);

   localparam int COL_W = (GLYPH_WIDTH > 1) ? $clog2(GLYPH_WIDTH) : 1;
   localparam int ROW_W = (GLYPH_HEIGHT > 1) ? $clog2(GLYPH_HEIGHT) : 1;
   localparam int AW    = FB_ADDR_WIDTH + 1;
   // Position sums must hold 16-bit x/y plus the cell offset without loss so
   // the clip compare sees the true coordinate; the address is wrapped later.
   localparam int PW    = (AW > 17) ? AW : 17;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_HEIGHT - 1);

   if (FB_ADDR_WIDTH < $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)) begin : g_fb_width_check
      $error("FB_ADDR_WIDTH too small for the screen");
   end
   if (ROM_ADDR_WIDTH < $clog2(SYMBOL_COUNT * GLYPH_HEIGHT)) begin : g_rom_width_check
      $error("ROM_ADDR_WIDTH too small for the glyph ROM");
   end

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAW} state_t;

   state_t                 state;
   logic [15:0]            x_q;
   logic [15:0]            y_q;
   logic [15:0]            sym_q;
   logic                   cur_l_q;
   logic                   cur_r_q;
   logic [ROW_W-1:0]       row;
   logic [COL_W-1:0]       col;
   logic [GLYPH_WIDTH-1:0] row_bits;

   logic [15:0]            sym_in;
   logic [ROW_W-1:0]       next_row;
   logic [COL_W-1:0]       tgt_col;
   logic [GLYPH_WIDTH-1:0] tgt_bits;
   logic [PW-1:0]          px;
   logic [PW-1:0]          py;
   logic [FB_ADDR_WIDTH-1:0] nxt_addr;
   logic                   nxt_data;
   logic                   nxt_vis;
   logic                   advance;

   function automatic logic [ROM_ADDR_WIDTH-1:0] rom_address(
      input logic [15:0]      s,
      input logic [ROW_W-1:0] r
   );
      return ROM_ADDR_WIDTH'(32'(s) * 32'(GLYPH_HEIGHT) + 32'(r));
   endfunction

   assign ready = (state == IDLE);

   // The pixel outputs are registered. This logic works out the pixel that the
   // outputs load next. In WAIT that is column 0, taken straight from the ROM
   // row that is arriving this cycle. In DRAW it is the column after the
   // current one, taken from the captured row.
   always_comb begin
      sym_in   = (32'(symbol) < 32'(SYMBOL_COUNT)) ? symbol : 16'd0;
      next_row = row + 1'b1;
      tgt_col  = (state == DRAW) ? col + 1'b1 : '0;
      tgt_bits = (state == DRAW) ? row_bits : glyph_rom_data;
      px       = PW'(x_q) + PW'(tgt_col);
      py       = PW'(y_q) + PW'(row);
      nxt_addr = FB_ADDR_WIDTH'(py * PW'(SCREEN_WIDTH) + px);
      nxt_data = tgt_bits[LAST_COL - tgt_col]
               | ((tgt_col == '0) && cur_l_q)
               | ((tgt_col == LAST_COL) && cur_r_q);
`ifdef SYMBOL_DRAWER_CLIP_EN
      nxt_vis  = (px < PW'(SCREEN_WIDTH)) && (py < PW'(SCREEN_HEIGHT));
`else
      nxt_vis  = 1'b1;
`endif
      // A skipped (clipped) column has no write request, so it retires
      // without waiting for the framebuffer.
      advance  = (state == DRAW) && (fb_can_write || !fb_write_enable);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         x_q             <= '0;
         y_q             <= '0;
         sym_q           <= '0;
         cur_l_q         <= 1'b0;
         cur_r_q         <= 1'b0;
         row             <= '0;
         col             <= '0;
         row_bits        <= '0;
         glyph_rom_addr  <= '0;
         fb_write_enable <= 1'b0;
         fb_write_addr   <= '0;
         fb_write_data   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_q            <= x;
                  y_q            <= y;
                  sym_q          <= sym_in;
                  cur_l_q        <= cursor_left;
                  cur_r_q        <= cursor_right;
                  row            <= '0;
                  col            <= '0;
                  // The address goes out on entry to FETCH. The ROM samples
                  // it at the end of FETCH, and the row is present in WAIT.
                  glyph_rom_addr <= rom_address(sym_in, '0);
                  state          <= FETCH;
               end
            end

            FETCH: begin
               state <= WAIT;
            end

            WAIT: begin
               row_bits        <= glyph_rom_data;
               col             <= '0;
               fb_write_enable <= nxt_vis;
               fb_write_addr   <= nxt_addr;
               fb_write_data   <= nxt_data;
               state           <= DRAW;
            end

            DRAW: begin
               // While stalled nothing changes, so addr and data stay stable.
               if (advance) begin
                  if (col == LAST_COL) begin
                     fb_write_enable <= 1'b0;
                     if (row == LAST_ROW) begin
                        state <= IDLE;
                     end else begin
                        row            <= next_row;
                        glyph_rom_addr <= rom_address(sym_q, next_row);
                        state          <= FETCH;
                     end
                  end else begin
                     col             <= tgt_col;
                     fb_write_enable <= nxt_vis;
                     fb_write_addr   <= nxt_addr;
                     fb_write_data   <= nxt_data;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
